// File: rtl/sram_port_arbiter_pkg.sv
// Shared SRAM-like bus definitions for the IF/MEM port arbiter.
package sram_port_arbiter_pkg;

  localparam int unsigned SRAM_REQ_LEN = 1 + 2 + 4 + 32 + 32;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/arb_owner_fifo.sv
// 1-bit-wide owner FIFO recording which requester issued each in-flight transaction.
module arb_owner_fifo #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH) + 1,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          din_i,
  input  logic          pop_i,
  output logic          head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap explicitly so a depth of 1 still behaves.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
    if (do_pop)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= din_i;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-to-one SRAM-like port arbiter (IF vs MEM) with in-order response routing.
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed data priority.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        resp_err
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

  sram_req_t     inst_bus, data_bus, mem_bus;
  logic [CW-1:0] count;
  logic          fifo_head, fifo_full, fifo_empty;
  logic          can_issue, prio_data, grant_data, grant_inst, accept, resp_valid;
  logic          resp_err_q, resp_err_d;

  assign inst_bus = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
  assign data_bus = {data_wr, data_size, data_wstrb, data_addr, data_wdata};

  // Registered count only: a same-cycle response never frees a slot for issue.
  assign can_issue  = (count != CW'(MAX_OUTSTANDING));
  assign grant_data = ~reset & data_req & can_issue & (prio_data | ~inst_req);
  assign grant_inst = ~reset & inst_req & can_issue & ~grant_data;
  assign mem_req    = grant_data | grant_inst;
  assign accept     = mem_req & mem_addr_ok;

  always_comb begin
    mem_bus = '0;
    if (grant_data)      mem_bus = data_bus;
    else if (grant_inst) mem_bus = inst_bus;
  end

  assign {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} = mem_bus;

  assign inst_addr_ok = grant_inst & mem_addr_ok;
  assign data_addr_ok = grant_data & mem_addr_ok;

  assign resp_valid   = ~reset & mem_data_ok & ~fifo_empty;
  assign inst_data_ok = resp_valid & (fifo_head == OWNER_INST);
  assign data_data_ok = resp_valid & (fifo_head == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  arb_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (accept & ~fifo_full),
    .din_i   (grant_data ? OWNER_DATA : OWNER_INST),
    .pop_i   (resp_valid),
    .head_o  (fifo_head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef SRAM_ARB_RR_EN
  logic prio_q, prio_d;

  // Loser of a contested, accepted grant gets priority next time.
  always_comb begin
    prio_d = prio_q;
    if (accept & inst_req & data_req) prio_d = ~grant_data;
  end

  always_ff @(posedge clk) begin
    if (reset) prio_q <= 1'b1;
    else       prio_q <= prio_d;
  end

  assign prio_data = prio_q;
`else
  assign prio_data = 1'b1;
`endif

  assign resp_err_d = resp_err_q | (mem_data_ok & fifo_empty);

  always_ff @(posedge clk) begin
    if (reset) resp_err_q <= 1'b0;
    else       resp_err_q <= resp_err_d;
  end

  assign resp_err = resp_err_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter (MAX_OUTSTANDING = 2).
module tb_sram_port_arbiter;

  logic        clk, reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_fails  = 0;

  logic [3:0] exp_dgrant;
  logic [3:0] exp_dresp;
  logic       exp_c4_dresp;

  sram_port_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_req    = 1'b0;
    data_req    = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
  endtask

  initial begin
`ifdef SRAM_ARB_RR_EN
    exp_dgrant   = 4'b0101;
    exp_dresp    = 4'b1010;
    exp_c4_dresp = 1'b0;
`else
    exp_dgrant   = 4'b1111;
    exp_dresp    = 4'b1110;
    exp_c4_dresp = 1'b1;
`endif
    reset = 1'b1;
    idle();
    inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hF; inst_addr = '0; inst_wdata = 32'h1111_2222;
    data_wr = 1'b1; data_size = 2'd0; data_wstrb = 4'h1; data_addr = '0; data_wdata = 32'h3333_4444;
    mem_rdata = '0;

    // Reset: outputs suppressed even with requests and responses present
    tick();
    inst_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_inst_addr_ok", inst_addr_ok, 1'b0);
    chk1("rst_inst_data_ok", inst_data_ok, 1'b0);
    chk1("rst_data_data_ok", data_data_ok, 1'b0);
    tick();
    chk1("rst_resp_err", resp_err, 1'b0);
    chk32("rst_count", 32'(dut.count), 32'd0);
    reset = 1'b0;
    idle();
    tick();

    // Inst only: zero-latency grant, response two cycles later
    inst_req = 1'b1; inst_addr = 32'h1C00_0000; mem_addr_ok = 1'b1;
    #1;
    chk1("t1_mem_req", mem_req, 1'b1);
    chk32("t1_mem_addr", mem_addr, 32'h1C00_0000);
    chk32("t1_mem_wdata", mem_wdata, 32'h1111_2222);
    chk32("t1_mem_ctl", 32'({mem_wr, mem_size, mem_wstrb}), 32'h2F);
    chk1("t1_inst_addr_ok", inst_addr_ok, 1'b1);
    chk1("t1_data_addr_ok", data_addr_ok, 1'b0);
    tick();
    idle();
    tick();
    mem_data_ok = 1'b1; mem_rdata = 32'h0280_0C0C;
    #1;
    chk1("t1_inst_data_ok", inst_data_ok, 1'b1);
    chk32("t1_inst_rdata", inst_rdata, 32'h0280_0C0C);
    chk1("t1_data_data_ok", data_data_ok, 1'b0);
    tick();
    idle();

    // Contention with data_addr = 0x1000; responses start on the second cycle
    inst_req = 1'b1; data_req = 1'b1; data_addr = 32'h0000_1000; mem_addr_ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      mem_data_ok = (c != 0);
      #1;
      chk1("t2_data_addr_ok", data_addr_ok, exp_dgrant[c]);
      chk1("t2_inst_addr_ok", inst_addr_ok, ~exp_dgrant[c]);
      chk32("t2_mem_addr", mem_addr, exp_dgrant[c] ? 32'h0000_1000 : 32'h1C00_0000);
      if (c != 0) begin
        chk1("t2_data_data_ok", data_data_ok, exp_dresp[c]);
        chk1("t2_inst_data_ok", inst_data_ok, ~exp_dresp[c]);
      end
      tick();
    end
    data_req = 1'b0;
    #1;
    chk1("t2_inst_after_drop", inst_addr_ok, 1'b1);
    chk1("t2_c4_data_data_ok", data_data_ok, exp_c4_dresp);
    tick();
    inst_req = 1'b0;
    #1;
    chk1("t2_last_inst_data_ok", inst_data_ok, 1'b1);
    tick();
    idle();
    #1;
    chk32("t2_count_drained", 32'(dut.count), 32'd0);

    // Out-of-slot: two accepted, third blocked; a response frees a slot next cycle
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    tick();
    inst_req = 1'b0; data_req = 1'b1;
    tick();
    data_req = 1'b0; inst_req = 1'b1;
    #1;
    chk1("t3_full_mem_req", mem_req, 1'b0);
    chk1("t3_full_inst_addr_ok", inst_addr_ok, 1'b0);
    tick();
    mem_data_ok = 1'b1;
    #1;
    chk1("t3_resp_inst_data_ok", inst_data_ok, 1'b1);
    chk1("t3_same_cycle_mem_req", mem_req, 1'b0);
    tick();
    mem_data_ok = 1'b0;
    #1;
    chk1("t3_next_inst_addr_ok", inst_addr_ok, 1'b1);
    tick();
    idle();
    mem_data_ok = 1'b1;
    #1;
    chk1("t3_drain_data", data_data_ok, 1'b1);
    tick();
    #1;
    chk1("t3_drain_inst", inst_data_ok, 1'b1);
    tick();
    idle();

    // Ordering: inst then data, responses routed in issue order
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    tick();
    inst_req = 1'b0; data_req = 1'b1;
    tick();
    idle();
    mem_data_ok = 1'b1; mem_rdata = 32'hAAAA_0000;
    #1;
    chk1("t4_first_inst_ok", inst_data_ok, 1'b1);
    chk1("t4_first_data_ok", data_data_ok, 1'b0);
    chk32("t4_inst_rdata", inst_rdata, 32'hAAAA_0000);
    tick();
    mem_rdata = 32'hBBBB_0000;
    #1;
    chk1("t4_second_data_ok", data_data_ok, 1'b1);
    chk1("t4_second_inst_ok", inst_data_ok, 1'b0);
    chk32("t4_data_rdata", data_rdata, 32'hBBBB_0000);
    tick();
    idle();

    // Simultaneous push and pop at count = 1
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    tick();
    inst_req = 1'b0; data_req = 1'b1; mem_data_ok = 1'b1;
    #1;
    chk1("t5_pop_inst_ok", inst_data_ok, 1'b1);
    chk1("t5_push_data_addr_ok", data_addr_ok, 1'b1);
    tick();
    data_req = 1'b0;
    #1;
    chk32("t5_count_held", 32'(dut.count), 32'd1);
    chk1("t5_pop_data_ok", data_data_ok, 1'b1);
    tick();
    idle();
    #1;
    chk32("t5_count_empty", 32'(dut.count), 32'd0);

    // Spurious response sets sticky error; reset clears it and in-flight state
    mem_data_ok = 1'b1;
    #1;
    chk1("t6_spur_inst_ok", inst_data_ok, 1'b0);
    chk1("t6_spur_data_ok", data_data_ok, 1'b0);
    tick();
    mem_data_ok = 1'b0;
    #1;
    chk1("t6_resp_err_set", resp_err, 1'b1);
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    tick();
    inst_req = 1'b0;
    #1;
    chk1("t6_resp_err_sticky", resp_err, 1'b1);
    chk32("t6_count_inflight", 32'(dut.count), 32'd1);
    reset = 1'b1; inst_req = 1'b1;
    #1;
    chk1("t6_rst_mem_req", mem_req, 1'b0);
    tick();
    reset = 1'b0; idle();
    #1;
    chk32("t6_count_after_rst", 32'(dut.count), 32'd0);
    chk1("t6_resp_err_cleared", resp_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-to-one arbiter sharing a single SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage). Each side uses the split-transaction SRAM-like handshake (`req`/`addr_ok` for the address phase, `data_ok` for the response). Responses return in order, so the arbiter tracks the owner of every outstanding transaction and routes each response back to the requester that issued it. It sits between the CPU core and the AXI bridge.

## Interface
- `MAX_OUTSTANDING`, 2: maximum in-flight transactions accepted downstream (power of two, 1–8).
- `clk` input 1: clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `inst_req`, `inst_wr`, `inst_size[1:0]`, `inst_wstrb[3:0]`, `inst_addr[31:0]`, `inst_wdata[31:0]` input: instruction requester address phase.
- `inst_addr_ok` output 1, `inst_data_ok` output 1, `inst_rdata` output 32: instruction handshake and response.
- `data_req`, `data_wr`, `data_size[1:0]`, `data_wstrb[3:0]`, `data_addr[31:0]`, `data_wdata[31:0]` input: data requester address phase.
- `data_addr_ok` output 1, `data_data_ok` output 1, `data_rdata` output 32: data handshake and response.
- `mem_req`, `mem_wr`, `mem_size[1:0]`, `mem_wstrb[3:0]`, `mem_addr[31:0]`, `mem_wdata[31:0]` output: shared downstream address phase.
- `mem_addr_ok` input 1, `mem_data_ok` input 1, `mem_rdata` input 32: downstream handshake and response.
- `resp_err` output 1: sticky flag, set when `mem_data_ok` arrives with no transaction outstanding.

## Operation
- Address handshake completes on a side when that side's `req` and `addr_ok` are both high in the same cycle. Requesters hold their request fields stable until `addr_ok`.
- `can_issue = (count != MAX_OUTSTANDING)`.
- Grant is combinational and decided every cycle:
  - `grant_data = data_req & can_issue & (prio_data | ~inst_req)`.
  - `grant_inst = inst_req & can_issue & ~grant_data`.
  - At most one grant per cycle.
- `mem_req = grant_data | grant_inst`. Downstream request fields are muxed from the granted side; they are all-zero when neither side is granted.
- `X_addr_ok = grant_X & mem_addr_ok`.
- On accept (`mem_req & mem_addr_ok`), the owner bit is pushed into the owner FIFO (1 = data, 0 = inst) and `count` increments.
- On `mem_data_ok` with `count != 0`:
  - The FIFO head selects the destination; that side's `data_ok` is pulsed and `mem_rdata` is forwarded to it.
  - The head is popped and `count` decrements.
  - `inst_rdata` and `data_rdata` are both driven by `mem_rdata` unconditionally; only `data_ok` is gated.
- Accept and response in the same cycle: push and pop both happen and `count` is unchanged. When `MAX_OUTSTANDING` are in flight, a same-cycle response does NOT free a slot for issue; `can_issue` uses the registered count.
- `mem_data_ok` with `count == 0`: no `data_ok` is asserted, `resp_err` is set to 1 and holds until reset.
- Write transactions also receive `data_ok` and occupy an outstanding slot.

## Timing
- Address path is zero latency: `X_req` → `mem_req` in the same cycle, and `mem_addr_ok` → `X_addr_ok` in the same cycle.
- Response path is zero latency: `mem_data_ok` → `X_data_ok` in the same cycle.
- Reset values:
  - Registers: `count` = 0, FIFO empty, `prio_data` = 1, `resp_err` = 0.
  - Outputs: all `*_addr_ok`/`*_data_ok` = 0 and `mem_req` = 0 while `reset` is high.
  - In-flight transactions are discarded; downstream must be reset together with this block.
- Pointer and count arithmetic is modulo `MAX_OUTSTANDING`; `count` is `$clog2(MAX_OUTSTANDING)+1` bits wide.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin. `prio_data` is a register that updates only on an accepted grant while both `inst_req` and `data_req` were high: it becomes 0 after data wins and 1 after inst wins.
- `SRAM_ARB_RR_EN` undefined: fixed priority. `prio_data` is the constant 1, so data always wins.

## Structure
- Shared package/macro header (the macro header already included by the pipeline stages) holds:
  - the SRAM-like request bundle width (`SRAM_REQ_LEN` = 1+2+4+32+32 = 71);
  - size encodings (0 = byte, 1 = half, 2 = word);
  - owner encodings `OWNER_INST` = 0 and `OWNER_DATA` = 1.
- One sub-module, `arb_owner_fifo`: a `MAX_OUTSTANDING`-deep, 1-bit-wide synchronous FIFO with push, pop, head, count, full and empty.

## Test plan
- Inst only: `inst_req`=1, `inst_addr`=0x1C000000, `mem_addr_ok`=1 → `mem_addr`=0x1C000000 and `inst_addr_ok`=1 in the same cycle. Two cycles later `mem_data_ok`=1, `mem_rdata`=0x02800C0C → `inst_data_ok`=1, `inst_rdata`=0x02800C0C, `data_data_ok`=0.
- Contention, fixed priority: both requests held, `data_addr`=0x00001000 → data is granted every cycle and inst is starved until `data_req` drops. With `SRAM_ARB_RR_EN` defined, grants alternate data, inst, data, inst.
- Out-of-slot: `MAX_OUTSTANDING`=2 with two accepts and no response → third request sees `mem_req`=0 and `addr_ok`=0. One `data_ok` → a new request is granted on the next cycle, not in the same cycle.
- Ordering: issue inst, data, then respond twice with 0xAAAA0000 then 0xBBBB0000 → `inst_data_ok` carries 0xAAAA0000 and `data_data_ok` carries 0xBBBB0000, in that order.
- Simultaneous push and pop at `count`=1 → `count` stays 1 and the owner order is preserved.
- Spurious `mem_data_ok` at `count`=0 → no `data_ok`, `resp_err`=1 stays set until `reset`. Asserting `reset` mid-transaction → `count` returns to 0 and `resp_err` clears.
